// File: rtl/recfg_delay_ctrl.sv
// Length controller for a reconfigurable delay chain: drains (or flushes) in-flight samples before applying a new length.
// Optional feature macro: RECFG_DELAY_CTRL_FLUSH_EN (skip DRAIN and discard in-flight samples on a length change).
module recfg_delay_ctrl #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned MIN_LEN = 0,
    localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          cfg_valid,
    input  logic [LW-1:0] cfg_len,
    output logic          cfg_ready,
    output logic          chain_en,
    output logic [LW-1:0] chain_len,
    output logic          out_valid,
    output logic          busy
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_SWITCH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      pend_q, pend_d;
    logic [LW-1:0]      cnt_q, cnt_d;
    logic [MAX_LEN-1:0] vsr_q, vsr_d;

    logic          in_ready_c, cfg_ready_c, chain_en_c, out_valid_c, busy_c;
    logic          in_fire, cfg_fire, tap;
    logic [LW-1:0] clen, len_m1;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            len_q   <= LW'(MIN_LEN);
            pend_q  <= LW'(MIN_LEN);
            cnt_q   <= '0;
            vsr_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            vsr_q   <= vsr_d;
        end
    end

    // Next-state, handshakes and chain control
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        vsr_d       = vsr_q;
        in_ready_c  = 1'b0;
        cfg_ready_c = 1'b0;
        chain_en_c  = 1'b0;
        busy_c      = 1'b0;

        if (cfg_len < LW'(MIN_LEN)) begin
            clen = LW'(MIN_LEN);
        end else if (cfg_len > LW'(MAX_LEN)) begin
            clen = LW'(MAX_LEN);
        end else begin
            clen = cfg_len;
        end

        // Handshakes are suppressed while reset is asserted
        if (rst_n) begin
            in_ready_c  = (state_q == S_RUN);
            cfg_ready_c = (state_q == S_RUN);
            busy_c      = (state_q != S_RUN);
        end
        in_fire  = in_valid & in_ready_c;
        cfg_fire = cfg_valid & cfg_ready_c;

        if (state_q == S_RUN) begin
            chain_en_c = in_fire;
        end else if (state_q == S_DRAIN) begin
            chain_en_c = rst_n;
        end

        len_m1      = len_q - LW'(1);
        tap         = |(vsr_q & (MAX_LEN'(1) << len_m1));
        out_valid_c = (len_q == '0) ? in_fire : (chain_en_c & tap);

        if (chain_en_c) begin
            vsr_d = (vsr_q << 1) | MAX_LEN'(in_fire);
        end
        if (len_q != '0) begin
            cnt_d = cnt_q + LW'(in_fire) - LW'(out_valid_c);
        end

        case (state_q)
            S_RUN: begin
                if (cfg_fire && (clen != len_q)) begin
                    pend_d = clen;
`ifdef RECFG_DELAY_CTRL_FLUSH_EN
                    state_d = S_SWITCH;
`else
                    state_d = S_DRAIN;
`endif
                end
            end
            S_DRAIN: begin
                // Last in-flight sample leaves this cycle (or none remain)
                if ((cnt_q == '0) || ((cnt_q == LW'(1)) && out_valid_c)) begin
                    state_d = S_SWITCH;
                end
            end
            S_SWITCH: begin
                len_d   = pend_q;
                vsr_d   = '0;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign in_ready  = in_ready_c;
    assign cfg_ready = cfg_ready_c;
    assign chain_en  = chain_en_c;
    assign chain_len = len_q;
    assign out_valid = out_valid_c;
    assign busy      = busy_c;

endmodule

// File: tb/tb_recfg_delay_ctrl.sv
// Self-checking bench for recfg_delay_ctrl: directed scenarios plus random traffic against a tagged delay-line model.
module tb_recfg_delay_ctrl;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned MIN_LEN = 0;
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);

    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_SWITCH = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          cfg_valid;
    logic [LW-1:0] cfg_len;
    logic          cfg_ready;
    logic          chain_en;
    logic [LW-1:0] chain_len;
    logic          out_valid;
    logic          busy;

    recfg_delay_ctrl #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfg_valid(cfg_valid),
        .cfg_len  (cfg_len),
        .cfg_ready(cfg_ready),
        .chain_en (chain_en),
        .chain_len(chain_len),
        .out_valid(out_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: a delay line of sample tags (-1 = empty slot)
    int m_mode, m_len, m_pend, m_tag;
    int pipe[MAX_LEN];
    int m_in_cnt, m_out_cnt, dut_out_cnt;
    int o_ir, o_ov, o_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < int'(MIN_LEN)) return int'(MIN_LEN);
        if (v > int'(MAX_LEN)) return int'(MAX_LEN);
        return v;
    endfunction

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < m_len; i++) if (pipe[i] >= 0) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_mode = M_RUN;
        m_len  = int'(MIN_LEN);
        m_pend = int'(MIN_LEN);
        for (int i = 0; i < int'(MAX_LEN); i++) pipe[i] = -1;
        m_in_cnt    = 0;
        m_out_cnt   = 0;
        dut_out_cnt = 0;
    endtask

    // One clock cycle: starts and ends 1 time unit after a rising edge
    task automatic step(input logic iv, input logic cv, input int cl);
        int e_ir, e_en, e_ov, e_busy, fire, cfire, c;
        in_valid  = iv;
        cfg_valid = cv;
        cfg_len   = LW'(cl);
        e_ir   = (m_mode == M_RUN) ? 1 : 0;
        fire   = (iv && e_ir != 0) ? 1 : 0;
        cfire  = (cv && e_ir != 0) ? 1 : 0;
        e_en   = (m_mode == M_RUN) ? fire : ((m_mode == M_DRAIN) ? 1 : 0);
        e_ov   = (m_len == 0) ? fire : ((e_en != 0 && pipe[m_len-1] >= 0) ? 1 : 0);
        e_busy = (m_mode != M_RUN) ? 1 : 0;
        #3;
        chk("in_ready", in_ready, e_ir);
        chk("cfg_ready", cfg_ready, e_ir);
        chk("chain_en", chain_en, e_en);
        chk("out_valid", out_valid, e_ov);
        chk("busy", busy, e_busy);
        chk("chain_len", chain_len, m_len);
        o_ir   = int'(in_ready);
        o_ov   = int'(out_valid);
        o_busy = int'(busy);
        if (out_valid === 1'b1) dut_out_cnt++;
        @(posedge clk);
        #1;
        if (fire != 0) m_in_cnt++;
        if (e_ov != 0) m_out_cnt++;
        if (e_en != 0) begin
            for (int i = int'(MAX_LEN) - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = (fire != 0) ? m_tag : -1;
            if (fire != 0) m_tag++;
        end
        case (m_mode)
            M_RUN: begin
                c = clamp(cl);
                if (cfire != 0 && c != m_len) begin
                    m_pend = c;
`ifdef RECFG_DELAY_CTRL_FLUSH_EN
                    m_mode = M_SWITCH;
`else
                    m_mode = M_DRAIN;
`endif
                end
            end
            M_DRAIN: if (occupancy() == 0) m_mode = M_SWITCH;
            default: begin
                m_len = m_pend;
                for (int i = 0; i < int'(MAX_LEN); i++) pipe[i] = -1;
                m_mode = M_RUN;
            end
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_cfg_ready"}, cfg_ready, 0);
        chk({tag, "_chain_en"}, chain_en, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_chain_len"}, chain_len, MIN_LEN);
    endtask

    task automatic do_reset();
        in_valid  = 1'b1;
        cfg_valid = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_reset_outputs("rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
    endtask

    int lows, pulses, nl;

    initial begin
        m_tag     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        cfg_valid = 1'b1;
        cfg_len   = LW'(5);
        model_reset();
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        cfg_valid = 1'b0;

        // Length 0 -> 4, then 10 back-to-back samples
        step(0, 1, 4);
        lows = 0;
        for (int i = 0; i < 4; i++) begin step(0, 0, 0); if (o_ir == 0) lows++; end
        chk("t1_stall", lows, 2);
        chk("t1_len", chain_len, 4);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin step(1, 0, 0); pulses += o_ov; end
        chk("t1_outs", pulses, 6);

        // Three samples in flight at length 4, change to 8 with in_valid held
        do_reset();
        step(0, 1, 4);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(0, 1, 8);
        lows = 0; pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            if (o_ir == 0) lows++;
            if (o_busy != 0 && o_ov != 0) pulses++;
        end
        chk("t2_stall", lows, 5);
        chk("t2_drain_outs", pulses, 3);
        chk("t2_len", chain_len, 8);

        // Over-range request clamps; same-length request is a no-op
        step(0, 1, 20);
        for (int i = 0; i < 12; i++) step(0, 0, 0);
        chk("t3_clamp", chain_len, 16);
        lows = 0;
        step(1, 1, 16);
        if (o_busy != 0 || o_ir == 0) lows++;
        for (int i = 0; i < 4; i++) begin step(1, 0, 0); if (o_busy != 0 || o_ir == 0) lows++; end
        chk("t3_nostall", lows, 0);

        // Zero length passes straight through; change to 2 stalls 2 cycles
        step(0, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        chk("t4_len0", chain_len, 0);
        step(1, 0, 0);
        chk("t4_same_cycle", o_ov, 1);
        step(0, 1, 2);
        lows = 0;
        for (int i = 0; i < 4; i++) begin step(0, 0, 0); if (o_ir == 0) lows++; end
        chk("t4_stall", lows, 2);

        // Reset asserted in the middle of DRAIN
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 6);
        step(0, 0, 0);
        chk("t5_in_drain", o_busy, 1);
        do_reset();
        step(0, 0, 0);
        chk("t5_after_len", chain_len, MIN_LEN);

`ifdef RECFG_DELAY_CTRL_FLUSH_EN
        // Flushed samples never appear; stall is a single cycle
        step(0, 1, 4);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(0, 1, 8);
        lows = 0; pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0);
            if (o_ir == 0) lows++;
            pulses += o_ov;
        end
        chk("t6_flush_stall", lows, 1);
        chk("t6_flush_outs", pulses, 0);
`endif

        // Random traffic and reconfiguration
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 31)));
        end

        // Force a final drain so every accepted sample has departed
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        nl = (m_len == 5) ? 6 : 5;
        step(0, 1, nl);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        chk("final_len", chain_len, nl);
`ifdef RECFG_DELAY_CTRL_FLUSH_EN
        chk("final_outs", dut_out_cnt, m_out_cnt);
`else
        chk("final_conservation", dut_out_cnt, m_in_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/recfg_delay_ctrl.md
RECFG_DELAY_CTRL -- requirements
Module: recfg_delay_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum delay-chain length in stages.
REQ-002 SHALL have parameter MIN_LEN, default 0: minimum delay-chain length.
REQ-003 SHALL let LW denote $clog2(MAX_LEN+1), the width of all length ports.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: upstream sample offered.
REQ-007 SHALL have port in_ready, output, 1: controller accepts the sample; in_fire = in_valid & in_ready.
REQ-008 SHALL have port cfg_valid, input, 1: new length requested.
REQ-009 SHALL have port cfg_len, input, LW: requested length.
REQ-010 SHALL have port cfg_ready, output, 1: request accepted; cfg_fire = cfg_valid & cfg_ready.
REQ-011 SHALL have port chain_en, output, 1: shift enable to the delay chain.
REQ-012 SHALL have port chain_len, output, LW: registered length applied to the delay chain.
REQ-013 SHALL have port out_valid, output, 1: the chain output holds a valid sample that departs this cycle.
REQ-014 SHALL have port busy, output, 1: high in DRAIN and SWITCH states.

Function
REQ-015 SHALL implement states RUN, DRAIN and SWITCH.
REQ-016 SHALL keep a MAX_LEN-bit valid shadow register vsr, shifted with bit0 <= in_fire only when chain_en = 1.
REQ-017 SHALL drive out_valid = in_fire when chain_len = 0; otherwise out_valid = chain_en & vsr[chain_len-1].
REQ-018 SHALL keep an in-flight counter cnt (LW bits), next cnt = cnt + in_fire - out_valid (chain_len > 0 only); it never exceeds chain_len.
REQ-019 SHALL, in RUN: drive in_ready = 1, cfg_ready = 1, chain_en = in_fire.
REQ-020 SHALL clamp the accepted length, clen = min(max(cfg_len, MIN_LEN), MAX_LEN).
REQ-021 SHALL, on cfg_fire in RUN with clen = chain_len, stay in RUN (no-op, no stall).
REQ-022 SHALL, on cfg_fire in RUN with clen != chain_len, latch clen into pend_len and enter DRAIN next cycle; an in_fire in the same cycle is still accepted.
REQ-023 SHALL, in DRAIN: drive in_ready = 0, cfg_ready = 0, chain_en = 1, and move to SWITCH in the cycle cnt = 0, or cnt = 1 with out_valid = 1.
REQ-024 SHALL, in SWITCH: drive in_ready = 0, cfg_ready = 0, chain_en = 0, load chain_len <= pend_len, clear vsr, and return to RUN.
REQ-025 SHALL bound DRAIN to at most chain_len cycles, giving a stall of at most chain_len+2 cycles per change.
REQ-026 SHALL, with chain_len = 0 and a change requested, pass DRAIN in one cycle (cnt = 0).
REQ-027 SHALL never drop or duplicate an accepted sample when the flush feature is excluded.

Reset
REQ-028 SHALL, while rst_n = 0, asynchronously force: state RUN, chain_len = MIN_LEN, pend_len = MIN_LEN, vsr = 0, cnt = 0.
REQ-029 SHALL hold in_ready = 0, cfg_ready = 0, chain_en = 0, out_valid = 0 and busy = 0 during reset.
REQ-030 SHALL, on reset during DRAIN or SWITCH, abandon the pending length; samples in flight are lost.

Configuration
REQ-031 SHALL, when macro RECFG_DELAY_CTRL_FLUSH_EN is defined, on a length-changing cfg_fire in RUN go directly to SWITCH, bypassing DRAIN.
REQ-032 SHALL, under RECFG_DELAY_CTRL_FLUSH_EN, never assert out_valid for flushed in-flight samples; the stall is exactly 1 cycle.
REQ-033 SHALL, without RECFG_DELAY_CTRL_FLUSH_EN, drain per REQ-022 to REQ-025; DRAIN is then the only path.

Verification
REQ-034 SHALL pass: reset, cfg_len = 4, then 10 back-to-back in_valid -> chain_len = 4 after SWITCH; each out_valid exactly 4 in_fires after its input.
REQ-035 SHALL pass: chain_len = 4 with 3 samples in flight, cfg_len = 8, in_valid held -> 3 out_valid pulses in DRAIN, in_ready low 5 cycles, then chain_len = 8.
REQ-036 SHALL pass: cfg_len = 20 with MAX_LEN = 16 -> chain_len = 16; cfg_len = chain_len -> no stall, busy stays 0.
REQ-037 SHALL pass: chain_len = 0 with in_valid -> out_valid same cycle as in_fire; change to 2 -> in_ready low 2 cycles.
REQ-038 SHALL pass: rst_n low mid-DRAIN -> state RUN, chain_len = MIN_LEN, out_valid 0 immediately.
REQ-039 SHALL pass, with RECFG_DELAY_CTRL_FLUSH_EN: 4 samples in flight and a change -> 0 out_valid for those samples, in_ready low 1 cycle.
